half_subtractor: RTL and testbench

Registered unsigned subtractor built from a half-subtractor cell at bit 0 and a ripple-borrow chain above it. Computes D = A − B (mod 2^WIDTH) and the borrow-out S. The default WIDTH = 1 is the classic half subtractor, with D = A xor B and S = (not A) and B. It sits in the arithmetic datapath as a leaf primitive with one-cycle registered outputs.

---
 rtl/half_subtractor_pkg.sv | 8 +
 rtl/half_subtractor_fs_cell.sv | 35 +++
 rtl/half_subtractor_hs_cell.sv | 15 +
 rtl/half_subtractor.sv | 56 +++++
 tb/tb_half_subtractor.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/half_subtractor_pkg.sv
// Shared constants for the registered ripple-borrow subtractor.
package half_subtractor_pkg;

  // Supported operand widths.
  localparam int unsigned MinWidth = 1;
  localparam int unsigned MaxWidth = 64;

endpackage

// File: rtl/half_subtractor_fs_cell.sv
// One-bit full subtractor built from two half-subtractor cells plus an OR.
module half_subtractor_fs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic d_ab;
  logic bout_ab;
  logic bout_in;

  // First stage subtracts the operand bits.
  half_subtractor_hs_cell u_hs_ab (
    .a_i    (a_i),
    .b_i    (b_i),
    .d_o    (d_ab),
    .bout_o (bout_ab)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_subtractor_hs_cell u_hs_in (
    .a_i    (d_ab),
    .b_i    (bin_i),
    .d_o    (d_o),
    .bout_o (bout_in)
  );

  // At most one stage can borrow, so OR merges them.
  always_comb begin
    bout_o = bout_ab | bout_in;
  end

endmodule

// File: rtl/half_subtractor_hs_cell.sv
// One-bit half subtractor: d = a - b, bout set when b > a.
module half_subtractor_hs_cell (
  input  logic a_i,
  input  logic b_i,
  output logic d_o,
  output logic bout_o
);

  // Difference and borrow of a single bit pair.
  always_comb begin
    d_o    = a_i ^ b_i;
    bout_o = ~a_i & b_i;
  end

endmodule

// File: rtl/half_subtractor.sv
// Registered unsigned subtractor: D = A - B mod 2^WIDTH, S = borrow-out (A < B).
// Half-subtractor at bit 0, ripple-borrow full-subtractor chain above it.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             S,
  output logic [WIDTH-1:0] D
);

  if (WIDTH < MinWidth || WIDTH > MaxWidth) begin : g_bad_width
    $error("half_subtractor: WIDTH out of range");
  end

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] d_q;
  logic             s_q;

  half_subtractor_hs_cell u_hs0 (
    .a_i    (A[0]),
    .b_i    (B[0]),
    .d_o    (diff[0]),
    .bout_o (borrow[0])
  );

  for (genvar i = 1; i < WIDTH; i++) begin : g_fs
    half_subtractor_fs_cell u_fs (
      .a_i    (A[i]),
      .b_i    (B[i]),
      .bin_i  (borrow[i-1]),
      .d_o    (diff[i]),
      .bout_o (borrow[i])
    );
  end

  // Difference and borrow are captured together so they always match one operand pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
      s_q <= 1'b0;
    end else begin
      d_q <= diff;
      s_q <= borrow[WIDTH-1];
    end
  end

  assign D = d_q;
  assign S = s_q;

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances on a shared clock and reset.
module tb_half_subtractor;

  logic       clk;
  logic       rst_n;
  logic [0:0] a1, b1, d1;
  logic       s1;
  logic [7:0] a8, b8, d8;
  logic       s8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit       w8;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       s;
  } vec_t;

  vec_t vecs[9];

  half_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a1),
    .B     (b1),
    .S     (s1),
    .D     (d1)
  );

  half_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a8),
    .B     (b8),
    .S     (s8),
    .D     (d8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {S, D} zero-extended to 9 bits.
  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got S/D=%b/%h expected S/D=%b/%h",
               name, act[8], act[7:0], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [8:0] w1_out();
    return {s1, 7'd0, d1};
  endfunction

  function automatic logic [8:0] w8_out();
    return {s8, d8};
  endfunction

  initial begin
    logic [8:0] prev;
    logic [7:0] ra, rb;
    logic [8:0] exp;

    vecs[0] = '{1'b0, 8'h0,  8'h0,  8'h0,  1'b0};
    vecs[1] = '{1'b0, 8'h0,  8'h1,  8'h1,  1'b1};
    vecs[2] = '{1'b0, 8'h1,  8'h0,  8'h1,  1'b0};
    vecs[3] = '{1'b0, 8'h1,  8'h1,  8'h0,  1'b0};
    vecs[4] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[5] = '{1'b1, 8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[6] = '{1'b1, 8'hA5, 8'hA5, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[8] = '{1'b1, 8'h00, 8'hFF, 8'h01, 1'b1};

    // Reset held with live operands: outputs must read zero immediately and stay there.
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1;
    a8 = 8'h12; b8 = 8'h34;
    #2;
    chk("rst_imm_w1", w1_out(), 9'h000);
    chk("rst_imm_w8", w8_out(), 9'h000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_w1", w1_out(), 9'h000);
    chk("rst_hold_w8", w8_out(), 9'h000);

    // Release between edges; first edge loads the live result.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("rel_pre_edge_w8", w8_out(), 9'h000);
    @(posedge clk);
    #1;
    chk("rel_first_w1", w1_out(), {1'b1, 8'h01});
    chk("rel_first_w8", w8_out(), {1'b1, 8'hDE});

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (vecs[i].w8) begin
        a8 = vecs[i].a; b8 = vecs[i].b;
      end else begin
        a1 = vecs[i].a[0:0]; b1 = vecs[i].b[0:0];
      end
      @(posedge clk);
      #1;
      if (vecs[i].w8) chk($sformatf("vec%0d_w8", i), w8_out(), {vecs[i].s, vecs[i].d});
      else            chk($sformatf("vec%0d_w1", i), w1_out(), {vecs[i].s, vecs[i].d});
    end

    // Back-to-back random pairs: old result held until the edge, new one right after it.
    prev = {1'b1, 8'h01};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("tp%0d_hold", i), w8_out(), prev);
      ra = 8'($urandom);
      rb = 8'($urandom);
      a8 = ra; b8 = rb;
      exp = {(ra < rb), 8'(ra - rb)};
      @(posedge clk);
      #1;
      chk($sformatf("tp%0d_res", i), w8_out(), exp);
      prev = exp;
    end

    // Make sure the outputs are nonzero going into the mid-stream reset.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20;
    a1 = 1'b0; b1 = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_w8", w8_out(), {1'b1, 8'hF0});

    // Async reset between edges clears before the next edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_imm_w1", w1_out(), 9'h000);
    chk("mid_rst_imm_w8", w8_out(), 9'h000);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_w8", w8_out(), 9'h000);

    @(negedge clk);
    a8 = 8'h40; b8 = 8'h0F;
    a1 = 1'b1; b1 = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("resume_pre_edge_w8", w8_out(), 9'h000);
    @(posedge clk);
    #1;
    chk("resume_w1", w1_out(), {1'b0, 8'h01});
    chk("resume_w8", w8_out(), {1'b0, 8'h31});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
